// File: rtl/tour_move_monitor.sv
// Knight's Tour move checker: tracks visited squares and the move count, and
// flags off-board, non-L, revisited or stalled moves reported by the tour logic.
module tour_move_monitor #(
   parameter int BOARD_W      = 5,
   parameter int BOARD_H      = 5,
   parameter int COORD_W      = 3,
   parameter int TIMEOUT_CLKS = 2000000,
   localparam int CNT_W       = $clog2(BOARD_W*BOARD_H+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] start_x,
   input  logic [COORD_W-1:0] start_y,
   input  logic               abort,
   input  logic               pos_vld,
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y,
   output logic               busy,
   output logic               move_ok,
   output logic               tour_done,
   output logic               err,
   output logic [2:0]         err_code,
   output logic [CNT_W-1:0]   move_cnt,
   output logic [COORD_W-1:0] cur_x,
   output logic [COORD_W-1:0] cur_y
);

   localparam int NSQ  = BOARD_W*BOARD_H;
   localparam int XW   = COORD_W+1;
   localparam int TO_W = $clog2(TIMEOUT_CLKS+1);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_OFF     = 3'd1;
   localparam logic [2:0] ERR_NOT_L   = 3'd2;
   localparam logic [2:0] ERR_REVISIT = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DONE, S_ERR} state_t;

   state_t             state_q;
   logic               busy_q, move_ok_q, tour_done_q, err_q;
   logic [2:0]         err_code_q;
   logic [CNT_W-1:0]   move_cnt_q;
   logic [COORD_W-1:0] cur_x_q, cur_y_q;
   logic [NSQ-1:0]     visited_q;
   logic [TO_W-1:0]    to_cnt_q;

   logic [NSQ-1:0]     pos_hit, st_hit;
   logic               pos_on, start_on, is_l, revisit;
   logic [XW-1:0]      dx, dy;
   logic [2:0]         fail_code;
   logic [CNT_W-1:0]   cnt_inc;

   // One-hot square decode; off-board coordinates match no square.
   for (genvar gi = 0; gi < NSQ; gi++) begin : g_sq
      assign pos_hit[gi] = ({1'b0, pos_x} == XW'(gi % BOARD_W)) &&
                           ({1'b0, pos_y} == XW'(gi / BOARD_W));
      assign st_hit[gi]  = ({1'b0, start_x} == XW'(gi % BOARD_W)) &&
                           ({1'b0, start_y} == XW'(gi / BOARD_W));
   end

   always_comb begin
      pos_on   = ({1'b0, pos_x} < XW'(BOARD_W)) && ({1'b0, pos_y} < XW'(BOARD_H));
      start_on = ({1'b0, start_x} < XW'(BOARD_W)) && ({1'b0, start_y} < XW'(BOARD_H));
      dx = (pos_x >= cur_x_q) ? ({1'b0, pos_x} - {1'b0, cur_x_q})
                              : ({1'b0, cur_x_q} - {1'b0, pos_x});
      dy = (pos_y >= cur_y_q) ? ({1'b0, pos_y} - {1'b0, cur_y_q})
                              : ({1'b0, cur_y_q} - {1'b0, pos_y});
      is_l    = ((dx == XW'(1)) && (dy == XW'(2))) || ((dx == XW'(2)) && (dy == XW'(1)));
      revisit = |(pos_hit & visited_q);
      cnt_inc = move_cnt_q + CNT_W'(1);
      fail_code = ERR_NONE;
      if (!pos_on)
         fail_code = ERR_OFF;
      else if (!is_l)
         fail_code = ERR_NOT_L;
      else if (revisit)
         fail_code = ERR_REVISIT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         move_ok_q   <= 1'b0;
         tour_done_q <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         move_cnt_q  <= '0;
         cur_x_q     <= '0;
         cur_y_q     <= '0;
         visited_q   <= '0;
         to_cnt_q    <= '0;
      end else begin
         move_ok_q <= 1'b0;
         err_q     <= 1'b0;
         if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            tour_done_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            move_cnt_q  <= '0;
            visited_q   <= '0;
            to_cnt_q    <= '0;
         end else if (start) begin
            tour_done_q <= 1'b0;
            to_cnt_q    <= '0;
            if (start_on) begin
               state_q    <= S_TRACK;
               busy_q     <= 1'b1;
               err_code_q <= ERR_NONE;
               visited_q  <= st_hit;
               cur_x_q    <= start_x;
               cur_y_q    <= start_y;
               move_cnt_q <= CNT_W'(1);
            end else begin
               state_q    <= S_ERR;
               busy_q     <= 1'b0;
               err_q      <= 1'b1;
               err_code_q <= ERR_OFF;
               visited_q  <= '0;
               move_cnt_q <= '0;
            end
         end else if (state_q == S_TRACK) begin
            if (pos_vld) begin
               to_cnt_q <= '0;
               if (fail_code != ERR_NONE) begin
                  state_q    <= S_ERR;
                  busy_q     <= 1'b0;
                  err_q      <= 1'b1;
                  err_code_q <= fail_code;
               end else begin
                  visited_q  <= visited_q | pos_hit;
                  cur_x_q    <= pos_x;
                  cur_y_q    <= pos_y;
                  move_cnt_q <= cnt_inc;
                  move_ok_q  <= 1'b1;
                  if (cnt_inc == CNT_W'(NSQ)) begin
                     state_q     <= S_DONE;
                     busy_q      <= 1'b0;
                     tour_done_q <= 1'b1;
                  end
               end
            end else if (to_cnt_q == TO_W'(TIMEOUT_CLKS-1)) begin
               state_q    <= S_ERR;
               busy_q     <= 1'b0;
               err_q      <= 1'b1;
               err_code_q <= ERR_TIMEOUT;
            end else begin
               to_cnt_q <= to_cnt_q + TO_W'(1);
            end
         end
      end
   end

   assign busy      = busy_q;
   assign move_ok   = move_ok_q;
   assign tour_done = tour_done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign move_cnt  = move_cnt_q;
   assign cur_x     = cur_x_q;
   assign cur_y     = cur_y_q;

endmodule
